// File: rtl/motion_update_scheduler.sv
// motion_update_scheduler: runs one motion-update pass over all position
// caches and round-robin arbitrates requester beats onto the shared cache bus.
//
// Ports:
//   clk, rst (async, active low)
//   in_start               - begin a pass (IDLE only)
//   in_req_valid/_data/
//   in_req_dst_cell/_done  - per-requester beat, destination, finished flag
//   out_req_ready          - one-hot grant (combinational)
//   out_motion_update_enable, out_data, out_data_dst_cell, out_data_valid
//                          - broadcast bus into the caches
//   out_busy, out_done, out_particle_count - pass status
module motion_update_scheduler #(
    parameter int DATA_WIDTH    = 32,
    parameter int CELL_ID_WIDTH = 4,
    parameter int NUM_REQ       = 4,
    parameter int REQ_ID_WIDTH  = 2,
    parameter int SETTLE_CYCLES = 3,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_start,
    input  logic [NUM_REQ-1:0]                   in_req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      in_req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   in_req_dst_cell,
    input  logic [NUM_REQ-1:0]                   in_req_done,
    output logic [NUM_REQ-1:0]                   out_req_ready,
    output logic                                 out_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 out_busy,
    output logic                                 out_done,
    output logic [COUNT_WIDTH-1:0]               out_particle_count
);

    localparam int BW = 3 * DATA_WIDTH;
    localparam int CW = 3 * CELL_ID_WIDTH;
    localparam int FW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BCAST,
        S_FLUSH
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [REQ_ID_WIDTH-1:0]  r_ptr;
    logic [FW-1:0]            r_flush;
    logic                     r_en;
    logic                     r_dv;
    logic [BW-1:0]            r_data;
    logic [CW-1:0]            r_dst;
    logic                     r_done;
    logic [COUNT_WIDTH-1:0]   r_count;

    logic [NUM_REQ-1:0]       w_gnt;
    logic [REQ_ID_WIDTH-1:0]  w_gidx;
    logic [BW-1:0]            w_sel_data;
    logic [CW-1:0]            w_sel_dst;
    logic                     w_xfer;
    logic                     w_exit;
    logic                     w_flush_last;
    int                       w_dist;
    int                       w_best;
    int                       w_best_idx;

    // Round-robin: each valid requester's distance from pointer+1 (mod N);
    // the smallest distance wins.
    always_comb begin
        w_dist     = 0;
        w_best     = NUM_REQ;
        w_best_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_dist = (i + NUM_REQ - int'(r_ptr) - 1) % NUM_REQ;
            if (in_req_valid[i] && (w_dist < w_best)) begin
                w_best     = w_dist;
                w_best_idx = i;
            end
        end
    end

    always_comb begin
        w_gnt      = '0;
        w_gidx     = r_ptr;
        w_sel_data = '0;
        w_sel_dst  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((r_state == S_BCAST) && (w_best < NUM_REQ)
                && (w_best_idx == i)) begin
                w_gnt[i]   = 1'b1;
                w_gidx     = REQ_ID_WIDTH'(i);
                w_sel_data = in_req_data[i*BW +: BW];
                w_sel_dst  = in_req_dst_cell[i*CW +: CW];
            end
        end
    end

    assign w_xfer       = |(w_gnt & in_req_valid);
    // A still-valid beat keeps the pass open even if every done is high.
    assign w_exit       = (&in_req_done) && !(|in_req_valid);
    assign w_flush_last = (r_flush == FW'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_start) begin
                    w_state_nxt = S_BCAST;
                end
            end
            S_BCAST: begin
                if (w_exit) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= REQ_ID_WIDTH'(NUM_REQ - 1);
            r_flush <= '0;
            r_en    <= 1'b0;
            r_dv    <= 1'b0;
            r_data  <= '0;
            r_dst   <= '0;
            r_done  <= 1'b0;
            r_count <= '0;
        end else begin
            r_done <= 1'b0;
            r_dv   <= 1'b0;
            r_data <= '0;
            r_dst  <= '0;
            case (r_state)
                S_IDLE: begin
                    r_flush <= '0;
                    if (in_start) begin
                        r_en    <= 1'b1;
                        r_count <= '0;
                    end
                end
                S_BCAST: begin
                    r_flush <= '0;
                    if (w_exit) begin
                        r_en <= 1'b0;
                    end else if (w_xfer) begin
                        r_dv   <= 1'b1;
                        r_data <= w_sel_data;
                        r_dst  <= w_sel_dst;
                        r_ptr  <= w_gidx;
                        if (r_count != {COUNT_WIDTH{1'b1}}) begin
                            r_count <= r_count + COUNT_WIDTH'(1);
                        end
                    end
                end
                S_FLUSH: begin
                    r_en <= 1'b0;
                    if (w_flush_last) begin
                        r_flush <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_flush <= r_flush + FW'(1);
                    end
                end
                default: begin
                    r_en    <= 1'b0;
                    r_flush <= '0;
                end
            endcase
        end
    end

    assign out_req_ready            = w_gnt;
    assign out_motion_update_enable = r_en;
    assign out_data                 = r_data;
    assign out_data_dst_cell        = r_dst;
    assign out_data_valid           = r_dv;
    assign out_busy                 = (r_state != S_IDLE);
    assign out_done                 = r_done;
    assign out_particle_count       = r_count;

endmodule

// File: tb/tb_motion_update_scheduler.sv
// Testbench for motion_update_scheduler: random requesters against a
// pass-level behavioural model, plus directed passes with literal results.
module tb_motion_update_scheduler;

    localparam int DW     = 32;
    localparam int CIW    = 4;
    localparam int NR     = 4;
    localparam int SETTLE = 3;
    localparam int BW     = 3 * DW;
    localparam int DCW    = 3 * CIW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_start;
    logic [NR-1:0]     in_req_valid;
    logic [NR*BW-1:0]  in_req_data;
    logic [NR*DCW-1:0] in_req_dst_cell;
    logic [NR-1:0]     in_req_done;
    logic [NR-1:0]     out_req_ready;
    logic              out_motion_update_enable;
    logic [BW-1:0]     out_data;
    logic [DCW-1:0]    out_data_dst_cell;
    logic              out_data_valid;
    logic              out_busy;
    logic              out_done;
    logic [15:0]       out_particle_count;

    motion_update_scheduler #(
        .DATA_WIDTH(DW), .CELL_ID_WIDTH(CIW), .NUM_REQ(NR),
        .REQ_ID_WIDTH(2), .SETTLE_CYCLES(SETTLE), .COUNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .in_start(in_start),
        .in_req_valid(in_req_valid), .in_req_data(in_req_data),
        .in_req_dst_cell(in_req_dst_cell), .in_req_done(in_req_done),
        .out_req_ready(out_req_ready),
        .out_motion_update_enable(out_motion_update_enable),
        .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
        .out_data_valid(out_data_valid), .out_busy(out_busy),
        .out_done(out_done), .out_particle_count(out_particle_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model: mode 0 idle, 1 broadcasting, 2 settling
    int          m_mode;
    int          m_last;
    int          m_fl;
    logic        m_en;
    logic        m_dv;
    logic        m_done;
    logic [BW-1:0]  m_data;
    logic [DCW-1:0] m_dst;
    logic [15:0] m_cnt;

    int      rq_left[NR];
    int      rq_early[NR];
    int      vprob;
    bit      busy_starts;
    bit      start_req;
    logic [NR-1:0] acc;

    int cyc, en_cycles, dv_cycles, done_pulses, done_off, g_first, g_last;
    int gq[$];
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (m_mode != 1) return -1;
        for (int k = 1; k <= NR; k++) begin
            if (in_req_valid[(m_last + k) % NR]) return (m_last + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_last = NR - 1; m_fl = 0;
        m_en = 0; m_dv = 0; m_done = 0;
        m_data = '0; m_dst = '0; m_cnt = '0;
    endtask

    task automatic model_step();
        int g;
        g = model_grant();
        m_done = 0;
        case (m_mode)
            0: if (in_start) begin
                m_mode = 1; m_en = 1; m_cnt = 0;
            end
            1: if (&in_req_done && in_req_valid == '0) begin
                m_mode = 2; m_en = 0; m_dv = 0;
                m_data = '0; m_dst = '0; m_fl = SETTLE;
            end else if (g >= 0) begin
                m_dv = 1;
                m_data = in_req_data[g*BW +: BW];
                m_dst = in_req_dst_cell[g*DCW +: DCW];
                m_last = g;
                if (m_cnt != 16'hffff) m_cnt++;
            end else begin
                m_dv = 0; m_data = '0; m_dst = '0;
            end
            default: begin
                m_fl--;
                if (m_fl == 0) begin
                    m_mode = 0; m_done = 1;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        int g;
        logic [NR-1:0] er;
        g = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", out_req_ready, er);
        chk("enable", out_motion_update_enable, m_en);
        chk("valid", out_data_valid, m_dv);
        chk("data", out_data, m_data);
        chk("dst", out_data_dst_cell, m_dst);
        chk("busy", out_busy, m_mode != 0);
        chk("done", out_done, m_done);
        chk("count", out_particle_count, m_cnt);
    endtask

    task automatic drive_stim();
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                rq_left[i]--;
                in_req_valid[i] = 1'b0;
            end
            if (!in_req_valid[i] && rq_left[i] > 0
                && int'($urandom_range(99)) < vprob) begin
                in_req_valid[i] = 1'b1;
                in_req_data[i*BW +: BW] = {$urandom(), $urandom(), $urandom()};
                in_req_dst_cell[i*DCW +: DCW] = DCW'($urandom());
            end
            in_req_done[i] = (rq_left[i] <= rq_early[i]);
        end
        in_start = start_req
            || (busy_starts && m_mode != 0 && $urandom_range(2) == 0);
        start_req = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        drive_stim();
        #1;
        check_outputs();
        acc = in_req_valid & out_req_ready;
        if (out_motion_update_enable) en_cycles++;
        if (out_data_valid) dv_cycles++;
        if (out_done) begin
            done_pulses++;
            if (done_off < 0) done_off = cyc;
        end
        for (int i = 0; i < NR; i++) begin
            if (out_req_ready[i]) begin
                gq.push_back(i);
                if (g_first < 0) g_first = cyc;
                g_last = cyc;
            end
        end
        cyc++;
        @(posedge clk);
        model_step();
    endtask

    task automatic reset_stats();
        cyc = 0; en_cycles = 0; dv_cycles = 0; done_pulses = 0;
        done_off = -1; g_first = -1; g_last = -1;
        gq.delete();
        acc = '0;
    endtask

    task automatic set_reqs(input int l0, input int l1, input int l2,
                            input int l3, input int early);
        rq_left[0] = l0; rq_left[1] = l1; rq_left[2] = l2; rq_left[3] = l3;
        for (int i = 0; i < NR; i++) rq_early[i] = early;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) rq_left[i] = 0;
        in_req_valid = '0;
        in_start = 0;
        busy_starts = 0;
        acc = '0;
    endtask

    task automatic run_pass();
        int tail;
        tail = -1;
        reset_stats();
        start_req = 1;
        for (int c = 0; c < 300; c++) begin
            cycle();
            if (m_done && tail < 0) tail = 2;
            else if (tail > 0) tail--;
            if (tail == 0) break;
        end
        chk("pass_completes", tail == 0, 1'b1);
        clear_reqs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        in_start = 0; in_req_valid = '0; in_req_data = '0;
        in_req_dst_cell = '0; in_req_done = '0;
        start_req = 0; busy_starts = 0; vprob = 100;
        set_reqs(0, 0, 0, 0, 0);
        model_reset();
        reset_stats();
        #1;
        check_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // contention: all four valid continuously
        set_reqs(2, 2, 2, 2, 0); vprob = 100;
        run_pass();
        chk("cont_ngrants", gq.size(), 8);
        for (int k = 0; k < 8 && k < gq.size(); k++)
            chk("cont_order", gq[k], exp_order[k]);
        chk("cont_no_gap", g_last - g_first, 7);
        chk("cont_count", out_particle_count, 8);

        // empty pass
        set_reqs(0, 0, 0, 0, 0);
        run_pass();
        chk("empty_en_cycles", en_cycles, 1);
        chk("empty_done_off", done_off, 5);
        chk("empty_count", out_particle_count, 0);
        chk("empty_done_pulses", done_pulses, 1);

        // single requester 2, three beats back to back
        set_reqs(0, 0, 3, 0, 0);
        run_pass();
        chk("single_count", out_particle_count, 3);
        chk("single_beats", dv_cycles, 3);
        chk("single_en_cycles", en_cycles, 4);
        chk("single_ngrants", gq.size(), 3);
        for (int k = 0; k < gq.size(); k++) chk("single_req", gq[k], 2);

        // done already high while two beats remain
        set_reqs(0, 2, 0, 0, 2);
        run_pass();
        chk("dwv_count", out_particle_count, 2);
        chk("dwv_beats", dv_cycles, 2);
        chk("dwv_en_cycles", en_cycles, 3);

        // starts pulsed while busy
        set_reqs(3, 1, 0, 2, 0); vprob = 60; busy_starts = 1;
        run_pass();
        chk("busy_done_pulses", done_pulses, 1);
        chk("busy_count", out_particle_count, 6);

        // random passes
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < NR; i++) begin
                rq_left[i] = int'($urandom_range(5));
                rq_early[i] = int'($urandom_range(2));
            end
            vprob = int'($urandom_range(100, 30));
            busy_starts = bit'($urandom_range(1));
            run_pass();
            chk("rand_done_pulses", done_pulses, 1);
        end

        // reset in the middle of a broadcast
        set_reqs(5, 5, 5, 5, 0); vprob = 100;
        reset_stats();
        start_req = 1;
        repeat (4) cycle();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("rst_enable", out_motion_update_enable, 1'b0);
        clear_reqs();
        @(negedge clk);
        rst = 1'b1;
        set_reqs(1, 1, 1, 1, 0); vprob = 100;
        run_pass();
        chk("rst_ngrants", gq.size(), 4);
        for (int k = 0; k < 4 && k < gq.size(); k++)
            chk("rst_order", gq[k], exp_order[k]);
        chk("rst_count", out_particle_count, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
